pwm_multi_channel: RTL
======================

Name: pwm_multi_channel

Overview:
Parametrised successor to the onboarding PWM peripheral: NUM_CH independent PWM outputs driven from one shared timebase. Adds a programmable period, a clock prescaler, edge- or centre-aligned counting, and shadow-registered duty/period/mode that update only at period boundaries, so outputs never glitch. Sits behind the SPI register file, which drives its enable, duty and configuration inputs; its outputs go to uo_out/uio_out.

Parameters:
NUM_CH, 16, number of PWM channels
CNT_W, 8, width of counter, period and each duty value
PRE_W, 8, width of prescale value

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  global run enable
center_mode  in  1  0 = edge-aligned, 1 = centre-aligned (shadowed)
prescale  in  PRE_W  timebase tick every prescale+1 clocks (live, not shadowed)
period  in  CNT_W  counter top value P (shadowed)
en_out  in  NUM_CH  per-channel output enable (live)
en_pwm  in  NUM_CH  per-channel PWM enable; 0 = static high when output enabled (live)
duty  in  NUM_CH*CNT_W  channel i duty at [i*CNT_W +: CNT_W] (shadowed)
pwm_out  out  NUM_CH  registered channel outputs
period_tick  out  1  one-clock pulse at each period boundary
cnt_out  out  CNT_W  current counter value (debug)

Behaviour:
- Reset, or rst high mid-operation: pre_cnt=0, cnt=0, dir=up, all shadows=0, pwm_out=0, period_tick=0. Takes effect on the first clock edge with rst high.
- enable=0: pre_cnt, cnt and dir held at reset values; shadows load from live inputs every clock; PWM term=0; period_tick=0.
- Prescaler: a tick is generated when pre_cnt >= prescale, which also clears pre_cnt; otherwise pre_cnt increments. Using >= means lowering prescale below the current pre_cnt ticks on the next clock and cannot lock up.
- The counter advances only on a tick.
- Edge mode: cnt runs 0..P_sh. A tick with cnt==P_sh is the boundary: cnt<=0. Period is P+1 ticks.
- Centre mode: cnt runs up 0..P_sh, then down to 0.
  - Up: a tick with cnt==P_sh sets dir=down and cnt<=P_sh-1.
  - Down: a tick with cnt==1 is the boundary: cnt<=0, dir=up.
  - Period is 2P ticks.
  - P_sh==0: cnt stays 0 and every tick is a boundary.
- Boundary: period_sh, center_sh and all duty_sh load from the live inputs, and period_tick=1 on the following clock.
- A mode change takes effect only at a boundary; dir is forced up then.
- PWM term for channel i: cnt < duty_sh[i].
  - Edge mode high ticks per period: min(D, P+1). D=0 is never high; D>P is always high.
  - Centre mode high ticks per period: 0 for D=0, 2D-1 for 1<=D<=P, 2P for D>P.
- Output register: pwm_out[i] <= en_out[i] ? (en_pwm[i] ? term : 1) : 0. One-clock latency from cnt and from the live enables.
- Duty writes mid-period never change the current period's waveform.

Decomposition:
- Package pwm_pkg: mode constants (PWM_EDGE=0, PWM_CENTER=1) and default widths CNT_W/PRE_W.
- Sub-module pwm_timebase: prescaler, counter, direction and boundary/period_tick generation; outputs cnt, boundary and center_sh.
- Top level: shadow registers plus a generate loop of per-channel comparators and output registers.

Test Plan:
1. Edge mode, P=255, prescale=0, ch0 D=128, ch1 D=0, all enabled -> ch0 high for exactly 128 of every 256 clocks, ch1 always 0, period_tick every 256 clocks.
2. Edge mode, P=99, ch2 D=200 -> ch2 constant 1. Then en_pwm[2]=0 -> 1. Then en_out[2]=0 -> 0 one clock later.
3. Edge mode, P=255, ch0 D=64; write D=192 at cnt=10 -> 64-high pattern completes, 192-high pattern starts the clock after period_tick.
4. Centre mode, P=10, D=4, prescale=0 -> 7 high of every 20 clocks, centred on cnt=0, period_tick every 20 clocks.
5. Edge mode, prescale=3, P=3 -> cnt steps every 4 clocks, period_tick every 16. Then set prescale=1 while pre_cnt=3 -> tick on the next clock, then every 2 clocks.
6. rst high 2 clocks mid-period with outputs high -> pwm_out=0, cnt_out=0, period_tick=0 after the first edge. Release -> first boundary on the first tick, then new duty/period take effect.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM block.
// Latency: n/a (package only).
// Backpressure: n/a.
package pwm_pkg;
  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;
  localparam int   DEF_CNT_W  = 8;
  localparam int   DEF_PRE_W  = 8;
endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up/up-down counter, boundary strobe, period_tick.
// Latency: period_tick is registered, one clock after the boundary edge.
// Backpressure: none; free-running while enable is high.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             center_mode,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] cnt,
  output logic             boundary,
  output logic             center_sh,
  output logic             period_tick
);

  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] period_sh;
  logic             dir_down;
  logic             tick;
  logic             at_end;
  logic [CNT_W-1:0] cnt_nxt;
  logic             dir_nxt;

  // >= rather than == so a prescale lowered below pre_cnt still ticks at once
  assign tick     = enable && (pre_cnt >= prescale);
  assign boundary = tick && at_end;

  always_comb begin
    cnt_nxt = cnt + CNT_W'(1);
    dir_nxt = dir_down;
    at_end  = 1'b0;
    if (center_sh == PWM_EDGE) begin
      if (cnt == period_sh) begin
        at_end  = 1'b1;
        cnt_nxt = '0;
      end
    end else if (!dir_down) begin
      if (cnt == period_sh) begin
        // P of 0 or 1 has no down leg: the top tick is itself the boundary
        if (period_sh <= CNT_W'(1)) begin
          at_end  = 1'b1;
          cnt_nxt = '0;
        end else begin
          dir_nxt = 1'b1;
          cnt_nxt = period_sh - CNT_W'(1);
        end
      end
    end else begin
      if (cnt <= CNT_W'(1)) begin
        at_end  = 1'b1;
        cnt_nxt = '0;
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
    if (at_end) dir_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt     <= '0;
      cnt         <= '0;
      dir_down    <= 1'b0;
      period_sh   <= '0;
      center_sh   <= PWM_EDGE;
      period_tick <= 1'b0;
    end else begin
      period_tick <= boundary;
      if (!enable) begin
        pre_cnt  <= '0;
        cnt      <= '0;
        dir_down <= 1'b0;
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        if (tick) begin
          cnt      <= cnt_nxt;
          dir_down <= dir_nxt;
        end
      end
      if (!enable || boundary) begin
        period_sh <= period;
        center_sh <= center_mode;
      end
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// NUM_CH PWM outputs sharing one timebase, duty shadowed to period boundaries.
// Latency: pwm_out one clock after cnt and after the live enables.
// Backpressure: none.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 16,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int PRE_W  = DEF_PRE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    center_mode,
  input  logic [PRE_W-1:0]        prescale,
  input  logic [CNT_W-1:0]        period,
  input  logic [NUM_CH-1:0]       en_out,
  input  logic [NUM_CH-1:0]       en_pwm,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick,
  output logic [CNT_W-1:0]        cnt_out
);

  logic [CNT_W-1:0]        cnt;
  logic                    boundary;
  logic                    center_sh;
  logic [NUM_CH*CNT_W-1:0] duty_sh;

  pwm_timebase #(
    .CNT_W (CNT_W),
    .PRE_W (PRE_W)
  ) u_timebase (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .center_mode (center_mode),
    .prescale    (prescale),
    .period      (period),
    .cnt         (cnt),
    .boundary    (boundary),
    .center_sh   (center_sh),
    .period_tick (period_tick)
  );

  assign cnt_out = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh <= '0;
    end else if (!enable || boundary) begin
      duty_sh <= duty;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic term;
    logic q;

    assign term       = enable && (cnt < duty_sh[i*CNT_W +: CNT_W]);
    assign pwm_out[i] = q;

    always_ff @(posedge clk) begin
      if (rst) begin
        q <= 1'b0;
      end else begin
        q <= en_out[i] ? (en_pwm[i] ? term : 1'b1) : 1'b0;
      end
    end
  end

endmodule
